// File: rtl/descrack_chain_scheduler_if.sv
// FSL daisy-chain link: head (scheduler -> chain) and tail (chain -> scheduler) with chain reset.
// Neither direction has backpressure; each valid word is consumed on the cycle it appears.
interface descrack_chain_scheduler_if;
  logic        fsl_rst_o;
  logic [31:0] fsl_data_o;
  logic        fsl_valid_o;
  logic [31:0] fsl_data_i;
  logic        fsl_valid_i;

  modport master (
    output fsl_rst_o, fsl_data_o, fsl_valid_o,
    input  fsl_data_i, fsl_valid_i
  );

  modport slave (
    input  fsl_rst_o, fsl_data_o, fsl_valid_o,
    output fsl_data_i, fsl_valid_i
  );
endinterface

// File: rtl/descrack_chain_scheduler.sv
// DES-crack chain scheduler: resets/configures the chain, deals keyspace chunks to idle cores, parses HIT/DONE returns.
// All outputs registered; JOB header leaves one cycle after core selection; no head backpressure, tail accepted every cycle.
module descrack_chain_scheduler #(
  parameter int NCORES     = 16,
  parameter int RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] cfg_pt,
  input  logic [63:0] cfg_ct,
  input  logic [55:0] cfg_key_base,
  input  logic [55:0] cfg_key_total,
  input  logic [31:0] cfg_chunk,
  output logic        busy,
  output logic        done,
  output logic        hit_valid,
  output logic [55:0] hit_key,
  output logic [7:0]  hit_core,
  output logic        err_proto,
  descrack_chain_scheduler_if.master fsl
);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_CFG, S_DISP, S_FIN} state_t;
  typedef enum logic [1:0] {RX_HDR, RX_KHI, RX_KLO} rx_t;

  localparam logic [7:0] OP_CFG  = 8'hCF;
  localparam logic [7:0] OP_JOB  = 8'hC0;
  localparam logic [7:0] OP_HIT  = 8'hE0;
  localparam logic [7:0] OP_DONE = 8'hD0;

  state_t            state_q, state_d;
  logic              rst_abort_q, rst_abort_d;
  logic [15:0]       rst_cnt_q, rst_cnt_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic              job_act_q, job_act_d;
  logic [7:0]        job_id_q, job_id_d;
  logic [55:0]       job_key_q, job_key_d;
  logic [31:0]       job_cnt_q, job_cnt_d;
  logic [63:0]       pt_q, pt_d;
  logic [63:0]       ct_q, ct_d;
  logic [55:0]       next_key_q, next_key_d;
  logic [55:0]       remaining_q, remaining_d;
  logic [31:0]       chunk_q, chunk_d;
  logic [NCORES-1:0] core_idle_q, core_idle_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hit_valid_q, hit_valid_d;
  logic [55:0]       hit_key_q, hit_key_d;
  logic [7:0]        hit_core_q, hit_core_d;
  logic              err_q, err_d;
  logic              fsl_rst_q, fsl_rst_d;
  logic [31:0]       fsl_data_q, fsl_data_d;
  logic              fsl_valid_q, fsl_valid_d;
  rx_t               rx_q, rx_d;
  logic [7:0]        rx_core_q, rx_core_d;
  logic [23:0]       rx_khi_q, rx_khi_d;

  logic [7:0]        rx_op, rx_id;
  logic              rx_id_ok, rx_id_busy;
  logic [NCORES-1:0] rx_mask, pick_mask;
  logic [7:0]        pick_id;
  logic              any_idle;
  logic [31:0]       disp_cnt;

  function automatic logic [31:0] cfg_word(input logic [2:0] idx, input logic [63:0] pt,
                                           input logic [63:0] ct);
    logic [31:0] w;
    case (idx)
      3'd0:    w = {OP_CFG, 8'hFF, 16'h0};
      3'd1:    w = pt[63:32];
      3'd2:    w = pt[31:0];
      3'd3:    w = ct[63:32];
      default: w = ct[31:0];
    endcase
    return w;
  endfunction

  function automatic logic [31:0] job_word(input logic [1:0] idx, input logic [7:0] id,
                                           input logic [55:0] key, input logic [31:0] cnt);
    logic [31:0] w;
    case (idx)
      2'd0:    w = {OP_JOB, id, 16'h0};
      2'd1:    w = {8'h0, key[55:32]};
      2'd2:    w = key[31:0];
      default: w = cnt;
    endcase
    return w;
  endfunction

  assign rx_op      = fsl.fsl_data_i[31:24];
  assign rx_id      = fsl.fsl_data_i[23:16];
  assign rx_id_ok   = ({1'b0, rx_id} < 9'(NCORES));
  assign rx_id_busy = |(rx_mask & ~core_idle_q);
  assign disp_cnt   = (remaining_q < {24'd0, chunk_q}) ? remaining_q[31:0] : chunk_q;

  // Lowest-index idle core wins; descending loop leaves the smallest index last.
  always_comb begin
    pick_id   = '0;
    any_idle  = 1'b0;
    rx_mask   = '0;
    pick_mask = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (core_idle_q[i]) begin
        pick_id  = 8'(i);
        any_idle = 1'b1;
      end
      rx_mask[i] = (rx_id == 8'(i));
    end
    for (int i = 0; i < NCORES; i++) begin
      pick_mask[i] = any_idle && (pick_id == 8'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    rst_abort_d = rst_abort_q;
    rst_cnt_d   = rst_cnt_q;
    wcnt_d      = wcnt_q;
    job_act_d   = job_act_q;
    job_id_d    = job_id_q;
    job_key_d   = job_key_q;
    job_cnt_d   = job_cnt_q;
    pt_d        = pt_q;
    ct_d        = ct_q;
    next_key_d  = next_key_q;
    remaining_d = remaining_q;
    chunk_d     = chunk_q;
    core_idle_d = core_idle_q;
    done_d      = 1'b0;
    hit_valid_d = 1'b0;
    hit_key_d   = hit_key_q;
    hit_core_d  = hit_core_q;
    err_d       = err_q;
    fsl_rst_d   = fsl_rst_q;
    fsl_data_d  = fsl_data_q;
    fsl_valid_d = fsl_valid_q;
    rx_d        = rx_q;
    rx_core_d   = rx_core_q;
    rx_khi_d    = rx_khi_q;

    // Tail parser: live whenever the chain is out of reset.
    if (fsl_rst_q) begin
      rx_d = RX_HDR;
    end else if (fsl.fsl_valid_i) begin
      case (rx_q)
        RX_HDR: begin
          if (rx_op == OP_HIT && rx_id_ok) begin
            rx_core_d = rx_id;
            rx_d      = RX_KHI;
          end else if (rx_op == OP_DONE && rx_id_ok) begin
            if (rx_id_busy) core_idle_d = core_idle_q | rx_mask;
            else            err_d       = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        RX_KHI: begin
          rx_khi_d = fsl.fsl_data_i[23:0];
          rx_d     = RX_KLO;
        end
        RX_KLO: begin
          hit_valid_d = 1'b1;
          hit_key_d   = {rx_khi_q, fsl.fsl_data_i};
          hit_core_d  = rx_core_q;
          rx_d        = RX_HDR;
        end
        default: rx_d = RX_HDR;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pt_d        = cfg_pt;
          ct_d        = cfg_ct;
          next_key_d  = cfg_key_base;
          remaining_d = cfg_key_total;
          chunk_d     = (cfg_chunk == 32'd0) ? 32'd1 : cfg_chunk;
          err_d       = 1'b0;
          rst_abort_d = 1'b0;
          rst_cnt_d   = '0;
          fsl_rst_d   = 1'b1;
          state_d     = S_RST;
        end
      end
      S_RST: begin
        core_idle_d = '1;
        if (rst_cnt_q == 16'(RST_CYCLES - 1)) begin
          fsl_rst_d = 1'b0;
          if (rst_abort_q) begin
            state_d = S_IDLE;
          end else begin
            state_d     = S_CFG;
            wcnt_d      = 3'd0;
            fsl_valid_d = 1'b1;
            fsl_data_d  = cfg_word(3'd0, pt_q, ct_q);
          end
        end else begin
          rst_cnt_d = rst_cnt_q + 16'd1;
        end
      end
      S_CFG: begin
        if (wcnt_q == 3'd4) begin
          fsl_valid_d = 1'b0;
          fsl_data_d  = '0;
          if (remaining_q == 56'd0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = S_DISP;
          end
        end else begin
          wcnt_d     = wcnt_q + 3'd1;
          fsl_data_d = cfg_word(wcnt_q + 3'd1, pt_q, ct_q);
        end
      end
      S_DISP: begin
        if (job_act_q) begin
          if (wcnt_q == 3'd3) begin
            job_act_d   = 1'b0;
            fsl_valid_d = 1'b0;
            fsl_data_d  = '0;
          end else begin
            wcnt_d     = wcnt_q + 3'd1;
            fsl_data_d = job_word(wcnt_q[1:0] + 2'd1, job_id_q, job_key_q, job_cnt_q);
          end
        end else if (remaining_q != 56'd0 && any_idle) begin
          job_act_d   = 1'b1;
          job_id_d    = pick_id;
          job_key_d   = next_key_q;
          job_cnt_d   = disp_cnt;
          wcnt_d      = 3'd0;
          fsl_valid_d = 1'b1;
          fsl_data_d  = job_word(2'd0, pick_id, next_key_q, disp_cnt);
          core_idle_d = core_idle_d & ~pick_mask;
          next_key_d  = next_key_q + {24'd0, disp_cnt};
          remaining_d = remaining_q - {24'd0, disp_cnt};
        end else if (remaining_q == 56'd0 && core_idle_q == {NCORES{1'b1}}) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the FSM chose this cycle and bypasses CFG on the way back.
    if (abort && state_q != S_IDLE) begin
      state_d     = S_RST;
      rst_abort_d = 1'b1;
      rst_cnt_d   = '0;
      fsl_rst_d   = 1'b1;
      fsl_valid_d = 1'b0;
      fsl_data_d  = '0;
      job_act_d   = 1'b0;
      done_d      = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rst_abort_q <= 1'b0;
      rst_cnt_q   <= '0;
      wcnt_q      <= '0;
      job_act_q   <= 1'b0;
      job_id_q    <= '0;
      job_key_q   <= '0;
      job_cnt_q   <= '0;
      pt_q        <= '0;
      ct_q        <= '0;
      next_key_q  <= '0;
      remaining_q <= '0;
      chunk_q     <= 32'd1;
      core_idle_q <= '1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_valid_q <= 1'b0;
      hit_key_q   <= '0;
      hit_core_q  <= '0;
      err_q       <= 1'b0;
      fsl_rst_q   <= 1'b0;
      fsl_data_q  <= '0;
      fsl_valid_q <= 1'b0;
      rx_q        <= RX_HDR;
      rx_core_q   <= '0;
      rx_khi_q    <= '0;
    end else begin
      state_q     <= state_d;
      rst_abort_q <= rst_abort_d;
      rst_cnt_q   <= rst_cnt_d;
      wcnt_q      <= wcnt_d;
      job_act_q   <= job_act_d;
      job_id_q    <= job_id_d;
      job_key_q   <= job_key_d;
      job_cnt_q   <= job_cnt_d;
      pt_q        <= pt_d;
      ct_q        <= ct_d;
      next_key_q  <= next_key_d;
      remaining_q <= remaining_d;
      chunk_q     <= chunk_d;
      core_idle_q <= core_idle_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hit_valid_q <= hit_valid_d;
      hit_key_q   <= hit_key_d;
      hit_core_q  <= hit_core_d;
      err_q       <= err_d;
      fsl_rst_q   <= fsl_rst_d;
      fsl_data_q  <= fsl_data_d;
      fsl_valid_q <= fsl_valid_d;
      rx_q        <= rx_d;
      rx_core_q   <= rx_core_d;
      rx_khi_q    <= rx_khi_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign hit_valid       = hit_valid_q;
  assign hit_key         = hit_key_q;
  assign hit_core        = hit_core_q;
  assign err_proto       = err_q;
  assign fsl.fsl_rst_o   = fsl_rst_q;
  assign fsl.fsl_data_o  = fsl_data_q;
  assign fsl.fsl_valid_o = fsl_valid_q;

endmodule

// File: tb/tb_descrack_chain_scheduler.sv
// Scoreboarded bench: a keyspace-dealing reference model queues expected head words, done pulses and hits;
// a negedge monitor pops and compares them while the stimulus plays the chain tail.
module tb_descrack_chain_scheduler;
  localparam int NC   = 2;
  localparam int RSTC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [63:0] cfg_pt = '0;
  logic [63:0] cfg_ct = '0;
  logic [55:0] cfg_key_base = '0;
  logic [55:0] cfg_key_total = '0;
  logic [31:0] cfg_chunk = '0;
  logic        busy, done, hit_valid, err_proto;
  logic [55:0] hit_key;
  logic [7:0]  hit_core;

  descrack_chain_scheduler_if fif();

  descrack_chain_scheduler #(.NCORES(NC), .RST_CYCLES(RSTC)) dut (
    .clk(clk), .rst(rst_n), .start(start), .abort(abort),
    .cfg_pt(cfg_pt), .cfg_ct(cfg_ct), .cfg_key_base(cfg_key_base),
    .cfg_key_total(cfg_key_total), .cfg_chunk(cfg_chunk),
    .busy(busy), .done(done), .hit_valid(hit_valid), .hit_key(hit_key),
    .hit_core(hit_core), .err_proto(err_proto), .fsl(fif)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] exp_q[$];
  int          exp_done = 0;
  logic [55:0] exp_hk[$];
  logic [7:0]  exp_hc[$];

  // Reference model of the keyspace dealer
  bit          m_idle[NC];
  logic [55:0] m_key, m_rem;
  logic [31:0] m_chunk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic bit m_all_idle();
    for (int i = 0; i < NC; i++) if (!m_idle[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_dispatch();
    while (m_rem != 56'd0) begin
      int c;
      logic [31:0] cnt;
      c = -1;
      for (int i = NC - 1; i >= 0; i--) if (m_idle[i]) c = i;
      if (c < 0) break;
      cnt = (m_rem < {24'd0, m_chunk}) ? m_rem[31:0] : m_chunk;
      exp_q.push_back({8'hC0, 8'(c), 16'h0});
      exp_q.push_back({8'h0, m_key[55:32]});
      exp_q.push_back(m_key[31:0]);
      exp_q.push_back(cnt);
      m_idle[c] = 1'b0;
      m_key = m_key + {24'd0, cnt};
      m_rem = m_rem - {24'd0, cnt};
    end
    if (m_rem == 56'd0 && m_all_idle()) exp_done++;
  endtask

  task automatic send_word(input logic [31:0] w);
    fif.fsl_valid_i = 1'b1;
    fif.fsl_data_i  = w;
    tick();
    fif.fsl_valid_i = 1'b0;
    fif.fsl_data_i  = '0;
  endtask

  task automatic send_hit(input logic [7:0] core, input logic [55:0] key);
    exp_hk.push_back(key);
    exp_hc.push_back(core);
    send_word({8'hE0, core, 16'h0});
    send_word({8'h0, key[55:32]});
    send_word(key[31:0]);
  endtask

  task automatic wait_q(input int k, input string nm);
    int t;
    t = 0;
    while (exp_q.size() > k && t < 3000) begin
      tick();
      t++;
    end
    n_chk++;
    if (exp_q.size() <= k) n_pass++;
    else $display("FAIL timeout_%s: %0d words still expected, required <= %0d", nm, exp_q.size(), k);
  endtask

  task automatic wait_drain(input string nm);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp_done != 0) && t < 3000) begin
      tick();
      t++;
    end
    n_chk++;
    if (exp_q.size() == 0 && exp_done == 0) n_pass++;
    else $display("FAIL drain_%s: words left %0d done pulses left %0d, required 0 and 0",
                  nm, exp_q.size(), exp_done);
  endtask

  task automatic begin_job(input logic [55:0] base, input logic [55:0] total, input logic [31:0] chunk);
    cfg_pt        = {$urandom, $urandom};
    cfg_ct        = {$urandom, $urandom};
    cfg_key_base  = base;
    cfg_key_total = total;
    cfg_chunk     = chunk;
    exp_q.push_back(32'hCFFF_0000);
    exp_q.push_back(cfg_pt[63:32]);
    exp_q.push_back(cfg_pt[31:0]);
    exp_q.push_back(cfg_ct[63:32]);
    exp_q.push_back(cfg_ct[31:0]);
    m_key   = base;
    m_rem   = total;
    m_chunk = (chunk == 32'd0) ? 32'd1 : chunk;
    for (int i = 0; i < NC; i++) m_idle[i] = 1'b1;
    m_dispatch();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  // pick_rand=0 retires the lowest busy core first, otherwise a random one.
  task automatic run_job(input logic [55:0] base, input logic [55:0] total, input logic [31:0] chunk,
                         input bit pick_rand);
    int bl[$];
    int c;
    begin_job(base, total, chunk);
    while (!m_all_idle()) begin
      wait_q($urandom_range(3, 0), "job_hdrs");
      if ($urandom_range(3, 0) == 0) send_hit(8'($urandom_range(NC - 1, 0)), {$urandom, $urandom});
      bl.delete();
      for (int i = 0; i < NC; i++) if (!m_idle[i]) bl.push_back(i);
      c = pick_rand ? bl[$urandom_range(bl.size() - 1, 0)] : bl[0];
      send_word({8'hD0, 8'(c), 16'h0});
      m_idle[c] = 1'b1;
      m_dispatch();
    end
    wait_drain("job");
    tick();
    tick();
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  // Monitor / scoreboard
  int rst_run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      rst_run = 0;
    end else begin
      if (fif.fsl_valid_o) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_head_word: got %08h expected no word", fif.fsl_data_o);
        end else begin
          chk("head_word", 64'(fif.fsl_data_o), 64'(exp_q.pop_front()));
        end
      end
      if (done) begin
        n_chk++;
        if (exp_done > 0) begin
          n_pass++;
          exp_done--;
        end else begin
          $display("FAIL unexpected_done: got done=1 expected 0");
        end
      end
      if (hit_valid) begin
        if (exp_hk.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_hit: got key %014h core %0d expected none", hit_key, hit_core);
        end else begin
          chk("hit_key", 64'(hit_key), 64'(exp_hk.pop_front()));
          chk("hit_core", 64'(hit_core), 64'(exp_hc.pop_front()));
        end
      end
      if (fif.fsl_rst_o) begin
        rst_run++;
      end else if (rst_run != 0) begin
        chk("fsl_rst_len", 64'(rst_run), 64'(RSTC));
        rst_run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fif.fsl_valid_i = 1'b0;
    fif.fsl_data_i  = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hit_valid", 64'(hit_valid), 64'd0);
    chk("rst_err", 64'(err_proto), 64'd0);
    chk("rst_fsl_rst", 64'(fif.fsl_rst_o), 64'd0);
    chk("rst_fsl_valid", 64'(fif.fsl_valid_o), 64'd0);
    chk("rst_fsl_data", 64'(fif.fsl_data_o), 64'd0);
    chk("rst_hit_key", 64'(hit_key), 64'd0);
    chk("rst_hit_core", 64'(hit_core), 64'd0);
    rst_n = 1'b1;
    tick();

    run_job(56'h10, 56'd5, 32'd2, 1'b0);
    run_job({$urandom, $urandom}, 56'd0, 32'd3, 1'b0);

    send_hit(8'd1, 56'hAB_CDEF_0123_4567);
    repeat (3) tick();
    chk("hit_seen", 64'(exp_hk.size()), 64'd0);

    send_word(32'hD000_0000);
    repeat (2) tick();
    chk("err_done_idle_core", 64'(err_proto), 64'd1);
    run_job(56'h0, 56'd0, 32'd1, 1'b0);
    chk("err_cleared_by_start", 64'(err_proto), 64'd0);
    send_word(32'h7700_0000);
    repeat (2) tick();
    chk("err_bad_header", 64'(err_proto), 64'd1);
    run_job(56'h0, 56'd0, 32'd1, 1'b0);
    send_word({8'hD0, 8'(NC), 16'h0});
    repeat (2) tick();
    chk("err_id_range", 64'(err_proto), 64'd1);
    repeat (10) tick();
    chk("err_sticky", 64'(err_proto), 64'd1);

    run_job(56'h1234, 56'd3, 32'd0, 1'b0);
    run_job(56'hFF_FFFF_FFFF_FFFE, 56'd5, 32'd2, 1'b1);
    for (int r = 0; r < 8; r++)
      run_job({$urandom, $urandom}, 56'($urandom_range(12, 1)), 32'($urandom_range(4, 0)), 1'b1);

    // Abort in the middle of the first JOB packet
    begin_job(56'h500, 56'd8, 32'd2);
    wait_q(6, "abort_point");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    exp_done = 0;
    for (int i = 0; i < NC; i++) m_idle[i] = 1'b1;
    repeat (8) tick();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_fsl_rst", 64'(fif.fsl_rst_o), 64'd0);
    send_hit(8'd0, {$urandom, $urandom});
    repeat (3) tick();
    chk("hit_after_abort_seen", 64'(exp_hk.size()), 64'd0);

    // Reset asserted while a JOB packet is on the head
    begin_job(56'h900, 56'd6, 32'd3);
    wait_q(7, "reset_point");
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(fif.fsl_valid_o), 64'd0);
    chk("midrst_data", 64'(fif.fsl_data_o), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    exp_done = 0;
    tick();
    rst_n = 1'b1;
    tick();

    run_job({$urandom, $urandom}, 56'd7, 32'd3, 1'b1);
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/descrack_chain_scheduler.md
Name: descrack_chain_scheduler

Overview:
- Host-side job scheduler for the DES-crack FSL daisy chain (regions of stream cores).
- Resets the chain, broadcasts plaintext/ciphertext, and carves the keyspace into per-core chunks injected as 32-bit FSL packets at the chain head.
- Parses packets returning from the chain tail, reports key hits, and re-dispatches each core as it finishes until the keyspace is exhausted.

Parameters:
- NCORES, 16, total cores on the chain; core IDs 0..NCORES-1, NCORES ≤ 255.
- RST_CYCLES, 4, cycles fsl_rst_o is held high at job start or abort.

Ports:
- clk  in  1  sole clock (FSL and scheduler).
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- abort  in  1  one-cycle pulse; any non-IDLE state.
- cfg_pt  in  64  plaintext; latched on start.
- cfg_ct  in  64  target ciphertext; latched on start.
- cfg_key_base  in  56  first key; latched on start.
- cfg_key_total  in  56  keys to search; latched on start.
- cfg_chunk  in  32  keys per dispatch; 0 is treated as 1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the search completes.
- hit_valid  out  1  one-cycle pulse per reported key.
- hit_key  out  56  key held with hit_valid.
- hit_core  out  8  reporting core held with hit_valid.
- err_proto  out  1  sticky; cleared by reset or start.
- fsl_rst_o  out  1  chain reset.
- fsl_data_o  out  32  chain head data.
- fsl_valid_o  out  1  chain head valid; no backpressure.
- fsl_data_i  in  32  chain tail data.
- fsl_valid_i  in  1  chain tail valid; must be accepted every cycle.

Behaviour:
- Reset values (all outputs): state IDLE; busy, done, hit_valid, err_proto, fsl_rst_o, fsl_valid_o = 0; fsl_data_o, hit_key, hit_core = 0; core_idle bitmap all 1.
- Outbound packet formats; words are emitted on consecutive cycles with fsl_valid_o high:
  - CFG packet, 5 words: {8'hCF, 8'hFF, 16'h0}, pt[63:32], pt[31:0], ct[63:32], ct[31:0].
  - JOB packet, 4 words: {8'hC0, id, 16'h0}, {8'h0, key[55:32]}, key[31:0], count[31:0].
- Inbound packet formats:
  - HIT packet, 3 words: {8'hE0, id, 16'h0}, {8'h0, key[55:32]}, key[31:0].
  - DONE packet, 1 word: {8'hD0, id, 16'h0}.
- FSM:
  - IDLE: on start, latch cfg, set next_key = base and remaining = total, clear err_proto, go RST.
  - RST: fsl_rst_o high for exactly RST_CYCLES cycles, core_idle set all 1, then go CFG.
  - CFG: emit the 5-word CFG packet. Next state is FIN if remaining == 0, else DISP.
  - DISP: if remaining > 0 and any core is idle, pick the lowest-index idle core c:
    - cnt = min(chunk, remaining);
    - emit the 4-word JOB packet; the header word is emitted the cycle after selection;
    - clear core_idle[c];
    - next_key += cnt (56-bit, wrap permitted);
    - remaining -= cnt.
  - DISP exit: if remaining == 0 and all cores are idle, go FIN. Otherwise wait in DISP with fsl_valid_o low.
  - FIN: pulse done for 1 cycle, go IDLE.
- Any non-IDLE state with abort: go RST, then IDLE (skip CFG), no done pulse. abort has priority over a same-cycle FSM transition.
- RX parser runs in every state except RST and accepts one word per fsl_valid_i cycle:
  - Unknown header, or id ≥ NCORES: drop the word, set err_proto.
  - HIT: after the 3rd word, pulse hit_valid with hit_key and hit_core 1 cycle later.
  - DONE for a busy core: set core_idle[id]. The updated bitmap is visible to DISP selection the following cycle.
  - DONE for an already-idle core: set err_proto, no bitmap change.
  - Mid-packet words are never interpreted as headers.
  - RX input is ignored while fsl_rst_o is high; the parser returns to header state.
- Simultaneous events:
  - A DONE arriving while a JOB packet is being emitted is processed normally.
  - A hit arriving in IDLE after an abort is still reported.
- Reset asserted mid-packet: the output word stream stops immediately and all state returns to reset values.

Test Plan:
- NCORES=2, base=0x10, total=5, chunk=2: CFG, then JOB(core0, key 0x10, cnt 2) and JOB(core1, key 0x12, cnt 2). After DONE(core0): JOB(core0, key 0x14, cnt 1). After DONE(core0) and DONE(core1): done pulse.
- total=0: fsl_rst_o high 4 cycles, CFG packet, done pulse, no JOB packet.
- HIT packet E0_01_0000, 00ABCDEF, 01234567 -> hit_valid 1 cycle, hit_key=0xABCDEF01234567, hit_core=1.
- DONE for an idle core, and header 0x77000000 -> err_proto=1 and stays 1 until the next start. No further JOB packets issue for the bogus DONE.
- abort during a JOB packet -> fsl_rst_o high 4 cycles, back to IDLE, busy=0, no done pulse.
- cfg_chunk=0, total=3, NCORES=1 -> three JOB packets with cnt=1 at keys base, base+1, base+2.
